// File: rtl/p_heap.sv
// Pipelined binary min-heap priority queue: one level per cycle, root always holds the minimum.
// Optional simulation-only request checks are compiled in when PHEAP_CHECK_EN is defined.
module p_heap #(
    parameter int DWIDTH = 32,
    parameter int HDEPTH = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enq,
    input  logic              deq,
    input  logic [DWIDTH-1:0] inp_data,
    output logic [DWIDTH-1:0] out_data,
    output logic              full,
    output logic              empty,
    output logic [HDEPTH-1:0] elem_cnt
);
    localparam int NODES = (1 << HDEPTH) - 1;

    typedef enum logic [1:0] {OP_NONE, OP_ENQ, OP_DEQ, OP_REP} op_e;
    typedef logic [HDEPTH-1:0] idx_t;

    // Nodes in breadth-first order: children of node g are 2g+1 and 2g+2.
    logic [DWIDTH-1:0] node_val [NODES];
    idx_t              node_cnt [NODES];

    // Token waiting to be processed at level k on the next edge.
    op_e               tok_op  [1:HDEPTH-1];
    logic [DWIDTH-1:0] tok_val [1:HDEPTH-1];
    idx_t              tok_idx [1:HDEPTH-1];

    logic              busy;
    op_e               acc_op;

    op_e               cur_op  [HDEPTH];
    logic [DWIDTH-1:0] cur_val [HDEPTH];
    idx_t              cur_idx [HDEPTH];

    logic              wr_en   [HDEPTH];
    idx_t              wr_idx  [HDEPTH];
    logic [DWIDTH-1:0] wr_val  [HDEPTH];
    idx_t              wr_cnt  [HDEPTH];
    op_e               nx_op   [HDEPTH];
    logic [DWIDTH-1:0] nx_val  [HDEPTH];
    idx_t              nx_idx  [HDEPTH];

    logic              last, l_ok, r_ok, pick_r;
    idx_t              g, li, ri, cidx;
    logic [DWIDTH-1:0] cval;

    assign out_data = node_val[0];
    assign elem_cnt = node_cnt[0];
    assign full     = (node_cnt[0] == idx_t'(NODES));
    assign empty    = (node_cnt[0] == '0);

    always_comb begin
        // A request is taken when the previous edge accepted nothing and the heap
        // can serve it; enq+deq on a non-empty heap becomes a replace.
        acc_op = OP_NONE;
        if (!busy) begin
            if (enq && deq && !empty)
                acc_op = OP_REP;
            else if (enq && !full)
                acc_op = OP_ENQ;
            else if (deq && !empty)
                acc_op = OP_DEQ;
        end

        cur_op[0]  = acc_op;
        cur_val[0] = inp_data;
        cur_idx[0] = '0;
        for (int k = 1; k < HDEPTH; k++) begin
            cur_op[k]  = tok_op[k];
            cur_val[k] = tok_val[k];
            cur_idx[k] = tok_idx[k];
        end

        last = 1'b0; l_ok = 1'b0; r_ok = 1'b0; pick_r = 1'b0;
        g = '0; li = '0; ri = '0; cidx = '0; cval = '0;
        for (int k = 0; k < HDEPTH; k++) begin
            last   = (k == HDEPTH - 1);
            g      = cur_idx[k];
            li     = last ? '0 : {g[HDEPTH-2:0], 1'b1};
            ri     = last ? '0 : li + 1'b1;
            l_ok   = !last && (node_cnt[li] != '0);
            r_ok   = !last && (node_cnt[ri] != '0);
            pick_r = r_ok && (!l_ok || (node_val[ri] < node_val[li]));
            cidx   = pick_r ? ri : li;
            cval   = pick_r ? node_val[ri] : node_val[li];

            wr_en[k]  = 1'b0;
            wr_idx[k] = g;
            wr_val[k] = node_val[g];
            wr_cnt[k] = node_cnt[g];
            nx_op[k]  = OP_NONE;
            nx_val[k] = cur_val[k];
            nx_idx[k] = cidx;

            case (cur_op[k])
                OP_ENQ: begin
                    wr_en[k]  = 1'b1;
                    wr_cnt[k] = node_cnt[g] + 1'b1;
                    if (node_cnt[g] == '0) begin
                        wr_val[k] = cur_val[k];
                    end else begin
                        nx_op[k] = OP_ENQ;
                        if (cur_val[k] < node_val[g]) begin
                            wr_val[k] = cur_val[k];
                            nx_val[k] = node_val[g];
                        end
                        // Larger value goes to the emptier subtree, left on a tie.
                        nx_idx[k] = (node_cnt[ri] < node_cnt[li]) ? ri : li;
                    end
                end
                OP_DEQ: begin
                    wr_en[k]  = 1'b1;
                    wr_cnt[k] = node_cnt[g] - 1'b1;
                    if (l_ok || r_ok) begin
                        wr_val[k] = cval;
                        nx_op[k]  = OP_DEQ;
                    end else begin
                        wr_val[k] = '1;
                    end
                end
                OP_REP: begin
                    wr_en[k] = 1'b1;
                    if ((l_ok || r_ok) && (cval < cur_val[k])) begin
                        wr_val[k] = cval;
                        nx_op[k]  = OP_REP;
                    end else begin
                        wr_val[k] = cur_val[k];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < NODES; i++) begin
                node_val[i] <= '1;
                node_cnt[i] <= '0;
            end
            for (int k = 1; k < HDEPTH; k++) begin
                tok_op[k]  <= OP_NONE;
                tok_val[k] <= '0;
                tok_idx[k] <= '0;
            end
            busy <= 1'b0;
        end else begin
            busy <= (acc_op != OP_NONE);
            // Tokens are two levels apart, so no two levels write the same node.
            for (int k = 0; k < HDEPTH; k++) begin
                if (wr_en[k]) begin
                    node_val[wr_idx[k]] <= wr_val[k];
                    node_cnt[wr_idx[k]] <= wr_cnt[k];
                end
            end
            for (int k = 1; k < HDEPTH; k++) begin
                tok_op[k]  <= nx_op[k-1];
                tok_val[k] <= nx_val[k-1];
                tok_idx[k] <= nx_idx[k-1];
            end
        end
    end

`ifdef PHEAP_CHECK_EN
    always @(posedge clk) begin
        if (!rst_n) begin
            if (enq && !deq && full)
                $error("p_heap: enq while full");
            if (deq && !enq && empty)
                $error("p_heap: deq while empty");
            if (busy && (enq || deq))
                $error("p_heap: request in the cycle after an accepted operation");
            if (32'(node_cnt[0]) > NODES)
                $error("p_heap: elem_cnt above capacity");
        end
    end
`endif

endmodule

// File: tb/tb_p_heap.sv
// Directed and random bench for p_heap: a queue-based software model tracks the stored
// multiset; a compare process checks count/flags every cycle and the root once settled.
module tb_p_heap;
    localparam int DW  = 32;
    localparam int HD  = 7;
    localparam int CAP = 127;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          enq = 1'b0;
    logic          deq = 1'b0;
    logic [DW-1:0] inp_data = '0;
    logic [DW-1:0] out_data;
    logic          full;
    logic          empty;
    logic [HD-1:0] elem_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int commit_cyc = 0;
    bit chk_on = 1'b0;

    logic [DW-1:0] model_q [$];
    logic [DW-1:0] exp_q [$];

    p_heap #(.DWIDTH(DW), .HDEPTH(HD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enq      (enq),
        .deq      (deq),
        .inp_data (inp_data),
        .out_data (out_data),
        .full     (full),
        .empty    (empty),
        .elem_cnt (elem_cnt)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [DW-1:0] model_min();
        logic [DW-1:0] m;
        m = '1;
        foreach (model_q[i]) if (model_q[i] < m) m = model_q[i];
        return m;
    endfunction

    function automatic void model_pop_min();
        int idx;
        idx = 0;
        foreach (model_q[i]) if (model_q[i] < model_q[idx]) idx = i;
        model_q.delete(idx);
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One request held for one cycle followed by one idle cycle; got = root seen during the request.
    task automatic do_op(input logic e, input logic d, input logic [DW-1:0] v, output logic [DW-1:0] got);
        bit a_rep, a_enq, a_deq;
        int n;
        @(negedge clk);
        enq = e;
        deq = d;
        inp_data = v;
        got = out_data;
        n = model_q.size();
        a_rep = e && d && (n > 0);
        a_enq = e && !a_rep && (n < CAP);
        a_deq = d && !e && (n > 0);
        if (a_rep || a_deq) begin
            exp_q.push_back(model_min());
            check("deq_value", got, exp_q.pop_front());
        end
        @(posedge clk);
        #1;
        if (a_rep) begin
            model_pop_min();
            model_q.push_back(v);
        end else if (a_deq) begin
            model_pop_min();
        end else if (a_enq) begin
            model_q.push_back(v);
        end
        if (a_rep || a_enq || a_deq) commit_cyc = cyc;
        @(negedge clk);
        enq = 1'b0;
        deq = 1'b0;
    endtask

    // Enqueue v1, then hold enq with v2 in the very next cycle, which must be ignored.
    task automatic back_to_back(input logic [DW-1:0] v1, input logic [DW-1:0] v2);
        @(negedge clk);
        enq = 1'b1;
        deq = 1'b0;
        inp_data = v1;
        @(posedge clk);
        #1;
        model_q.push_back(v1);
        commit_cyc = cyc;
        @(negedge clk);
        inp_data = v2;
        @(negedge clk);
        enq = 1'b0;
    endtask

    // Scoreboard compare process
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                check("elem_cnt", DW'(elem_cnt), DW'(model_q.size()));
                check("empty", DW'(empty), DW'(model_q.size() == 0));
                check("full", DW'(full), DW'(model_q.size() == CAP));
                if (cyc > commit_cyc) check("out_data", out_data, model_min());
            end
        end
    end

    initial begin
        logic [DW-1:0] got;
        logic [DW-1:0] vals [4];
        logic [DW-1:0] srt [4];
        int r;

        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        check("reset_out", out_data, 32'hFFFF_FFFF);
        check("reset_empty", DW'(empty), 32'd1);
        check("reset_full", DW'(full), 32'd0);
        check("reset_cnt", DW'(elem_cnt), 32'd0);
        chk_on = 1'b1;

        // Sorted output
        vals = '{32'd50, 32'd20, 32'd70, 32'd10};
        srt  = '{32'd10, 32'd20, 32'd50, 32'd70};
        for (int i = 0; i < 4; i++) do_op(1'b1, 1'b0, vals[i], got);
        @(negedge clk);
        check("sorted_min", out_data, 32'd10);
        check("sorted_cnt", DW'(elem_cnt), 32'd4);
        for (int i = 0; i < 4; i++) begin
            do_op(1'b0, 1'b1, '0, got);
            check("sorted_deq", got, srt[i]);
        end
        @(negedge clk);
        check("sorted_empty", DW'(empty), 32'd1);

        // Dequeue when empty
        do_op(1'b0, 1'b1, '0, got);
        @(negedge clk);
        check("empty_deq_cnt", DW'(elem_cnt), 32'd0);
        check("empty_deq_out", out_data, 32'hFFFF_FFFF);

        // Replace
        do_op(1'b1, 1'b0, 32'd12, got);
        do_op(1'b1, 1'b0, 32'd5, got);
        do_op(1'b1, 1'b0, 32'd9, got);
        do_op(1'b1, 1'b1, 32'd7, got);
        check("rep_ret", got, 32'd5);
        @(negedge clk);
        check("rep_out", out_data, 32'd7);
        check("rep_cnt", DW'(elem_cnt), 32'd3);
        do_op(1'b0, 1'b1, '0, got); check("rep_drain0", got, 32'd7);
        do_op(1'b0, 1'b1, '0, got); check("rep_drain1", got, 32'd9);
        do_op(1'b0, 1'b1, '0, got); check("rep_drain2", got, 32'd12);

        // enq+deq on an empty heap is a plain enqueue
        do_op(1'b1, 1'b1, 32'd25, got);
        @(negedge clk);
        check("empty_rep_out", out_data, 32'd25);
        check("empty_rep_cnt", DW'(elem_cnt), 32'd1);
        do_op(1'b0, 1'b1, '0, got);
        check("empty_rep_deq", got, 32'd25);

        // Request in the cycle after an accepted one is ignored
        back_to_back(32'd40, 32'd3);
        @(negedge clk);
        check("b2b_out", out_data, 32'd40);
        check("b2b_cnt", DW'(elem_cnt), 32'd1);
        do_op(1'b0, 1'b1, '0, got);
        check("b2b_deq", got, 32'd40);

        // Fill to capacity
        for (int i = CAP; i >= 1; i--) do_op(1'b1, 1'b0, DW'(i), got);
        @(negedge clk);
        check("fill_full", DW'(full), 32'd1);
        check("fill_cnt", DW'(elem_cnt), 32'd127);
        check("fill_out", out_data, 32'd1);
        do_op(1'b1, 1'b0, 32'd0, got);
        @(negedge clk);
        check("fill_ign_out", out_data, 32'd1);
        check("fill_ign_cnt", DW'(elem_cnt), 32'd127);
        for (int i = 1; i <= CAP; i++) begin
            do_op(1'b0, 1'b1, '0, got);
            check("fill_deq", got, DW'(i));
        end

        // Reset while a dequeue is still travelling down the levels
        for (int i = 0; i < 6; i++) do_op(1'b1, 1'b0, DW'(60 + i), got);
        do_op(1'b0, 1'b1, '0, got);
        #2;
        rst_n = 1'b1;
        model_q.delete();
        #1;
        check("midrst_out", out_data, 32'hFFFF_FFFF);
        check("midrst_cnt", DW'(elem_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        do_op(1'b1, 1'b0, 32'd8, got);
        do_op(1'b1, 1'b0, 32'd4, got);
        do_op(1'b1, 1'b0, 32'd6, got);
        @(negedge clk);
        check("postrst_out", out_data, 32'd4);
        check("postrst_cnt", DW'(elem_cnt), 32'd3);
        for (int i = 0; i < 3; i++) do_op(1'b0, 1'b1, '0, got);

        // Random mix with 16-bit keys
        for (int n = 0; n < 10000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 46)
                do_op(1'b1, 1'b0, DW'($urandom_range(0, 65535)), got);
            else if (r < 92)
                do_op(1'b0, 1'b1, '0, got);
            else
                do_op(1'b1, 1'b1, DW'($urandom_range(0, 65535)), got);
        end

        @(negedge clk);
        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/p_heap.md
# p_heap

Pipelined binary min-heap priority queue holding up to 127 entries in seven registered levels: one root plus levels of 2, 4, 8, 16, 32 and 64 nodes. It sits between the event producer and the scheduler. It accepts one enqueue, dequeue or replace operation every second clock and always presents the current minimum on `out_data`. Enqueue and dequeue travel down the levels one level per cycle, so the root is correct one cycle after each accepted operation.

## Interface
- `DWIDTH`, 32: key/data width; the entire word is the priority key, compared unsigned.
- `HDEPTH`, 7: number of heap levels; capacity is 2^HDEPTH−1 = 127.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-high.
- `enq`  in  1  enqueue `inp_data` this cycle.
- `deq`  in  1  remove the minimum this cycle.
- `inp_data`  in  DWIDTH  value to enqueue.
- `out_data`  out  DWIDTH  current minimum; this is the root register L0.
- `full`  out  1  high when `elem_cnt` == 127.
- `empty`  out  1  high when `elem_cnt` == 0.
- `elem_cnt`  out  HDEPTH  number of stored elements.

## Operation
- **Empty slots:** every empty slot holds the sentinel all-ones.
- **Occupancy counters:** every node keeps an occupancy count for its subtree.
- **Reset:**
  - all nodes are set to all-ones and all counters to 0.
  - `out_data` = all-ones, `elem_cnt` = 0, `empty` = 1, `full` = 0.
- **Enqueue** (`enq` only, not full):
  - the carried value is compared with each node on its path.
  - the smaller value stays in the node; the larger value continues to the child subtree with the lower occupancy (left child on a tie).
  - the operation ends when it reaches an empty slot; `elem_cnt` +1.
- **Dequeue** (`deq` only, not empty):
  - the root is removed and a hole descends the heap.
  - at each level the hole is filled with the smaller child, and the hole moves to that child.
  - the final hole becomes all-ones; that subtree's counters −1; `elem_cnt` −1.
- **Replace** (`enq` and `deq`, not empty):
  - the old root is removed, and `inp_data` sifts down from the root like a dequeue hole.
  - at each level the node takes min(carried value, smaller child).
  - `elem_cnt` is unchanged.
- **Boundary cases:**
  - `enq` when full is ignored.
  - `deq` when empty is ignored; `out_data` stays all-ones.
  - `enq`+`deq` when empty is treated as a plain enqueue.
- **Equal keys:** may emerge in any order.

## Timing
- `out_data` always shows the root register.
- The value removed by a `deq` is the `out_data` visible during that `deq` cycle; the test bench samples it at that clock edge.
- **Commit:** an operation is accepted on the rising edge where its request is high; `elem_cnt`, `full` and `empty` update on that same edge.
- **Root:** the new root value is valid from edge t+1 onward.
- **Pipeline:** each level is processed one cycle after the level above it, so an operation leaves the deepest level at t+HDEPTH−1.
  - Several operations may be in flight at once, one per alternate level.
  - Level contents below in-flight operations may transiently violate heap order; the root never does.
- **Issue rate:**
  - at most one operation every 2 cycles; the minimum spacing is one idle cycle.
  - A request in the cycle right after an accepted operation is ignored.
- **Reset mid-operation:** all in-flight operations are discarded immediately.

## Configuration
- `PHEAP_CHECK_EN`:
  - **Defined:** simulation-only checks print an error for an enq while full, a deq while empty, a request in the cycle after an accepted operation, or `elem_cnt` > 127.
  - **Undefined:** no checking logic and identical functional behaviour.

## Test plan
- **Reset:** after reset, `out_data` = 0xFFFFFFFF, `empty` = 1, `elem_cnt` = 0.
- **Sorted output:** enqueue 50, 20, 70, 10 every other cycle.
  - `out_data` = 10 and `elem_cnt` = 4.
  - Dequeues every other cycle return 10, 20, 50, 70, then `empty` = 1.
- **Fill:** enqueue 127 values 127 down to 1 → `full` = 1 and `elem_cnt` = 127.
  - A 128th enq of 0 is ignored and `out_data` stays 1.
  - 127 dequeues return 1..127 in order.
- **Replace:** with {5, 9, 12} stored, `enq`+`deq` with data 7 returns 5; `out_data` becomes 7 and `elem_cnt` stays 3.
- **Empty dequeue:** `deq` when empty leaves `elem_cnt` = 0 and `out_data` = 0xFFFFFFFF.
- **Random mix:** 10,000 random enq/deq operations with 16-bit keys, every other cycle, against a software model.
  - Every dequeued value must equal the model minimum, and `elem_cnt` must match the model.
